// File: rtl/mem_bus_bridge_if.sv
// Bundles the CPU request port and the valid/ready memory bus of mem_bus_bridge.
// The slave modport is the bridge's view; master is the CPU-plus-memory side.
interface mem_bus_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              cpu_req;
   logic              cpu_rw;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cpu_busy;
   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_err;
   logic [CNT_W-1:0]  txn_count;

   modport slave (
      input  cpu_req, cpu_rw, cpu_address, cpu_wdata, mem_ready, mem_rdata,
      output cpu_rdata, cpu_ready, cpu_busy, mem_valid, mem_we, mem_addr,
             mem_wdata, bus_err, txn_count
   );

   modport master (
      output cpu_req, cpu_rw, cpu_address, cpu_wdata, mem_ready, mem_rdata,
      input  cpu_rdata, cpu_ready, cpu_busy, mem_valid, mem_we, mem_addr,
             mem_wdata, bus_err, txn_count
   );
endinterface

// File: rtl/mem_bus_bridge.sv
// Single-request CPU-to-memory bridge: IDLE -> WAIT -> DONE, one cpu_ready pulse per access.
// Optional hung-access abort is enabled by defining BUS_TIMEOUT_EN.
//
//   state  | meaning
//   S_IDLE | waiting for cpu_req; request regs loaded on acceptance
//   S_WAIT | mem_valid high, holding the beat until mem_ready (or abort)
//   S_DONE | one-cycle cpu_ready pulse, transaction counted
module mem_bus_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic            clock,
   input logic            reset,
   mem_bus_bridge_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_we;
   logic [CNT_W-1:0]  r_count;
   logic              w_accept;
   logic              w_complete;
   logic              w_abort;
   logic              w_mem_valid;
   logic              w_cpu_ready;
   logic              w_cpu_busy;

   assign w_accept   = (r_state == S_IDLE) && bus.cpu_req;
   assign w_complete = (r_state == S_WAIT) && bus.mem_ready;

`ifdef BUS_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] r_tmo;
   logic             r_err;

   // Abort on the WAIT cycle that would bring the stall count to the limit.
   assign w_abort = (r_state == S_WAIT) && !bus.mem_ready &&
                    (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept)
            r_tmo <= '0;
         else if ((r_state == S_WAIT) && !bus.mem_ready)
            r_tmo <= r_tmo + 1'b1;
         if (w_accept)
            r_err <= 1'b0;
         else if (w_abort)
            r_err <= 1'b1;
      end
   end

   assign bus.bus_err = r_err;
`else
   assign w_abort     = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_valid = 1'b0;
      w_cpu_ready = 1'b0;
      w_cpu_busy  = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            w_cpu_busy = 1'b0;
            if (bus.cpu_req) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_mem_valid = 1'b1;
            if (w_complete || w_abort) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_cpu_ready = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_rdata <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= bus.cpu_address;
            r_wdata <= bus.cpu_wdata;
            r_we    <= ~bus.cpu_rw;
         end
         // Writes leave the last read value visible to the CPU.
         if (w_complete && !r_we)
            r_rdata <= bus.mem_rdata;
         else if (w_abort && !r_we)
            r_rdata <= '1;
         if (r_state == S_DONE)
            r_count <= r_count + 1'b1;
      end
   end

   assign bus.mem_valid = w_mem_valid;
   assign bus.cpu_ready = w_cpu_ready;
   assign bus.cpu_busy  = w_cpu_busy;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_we    = r_we;
   assign bus.cpu_rdata = r_rdata;
   assign bus.txn_count = r_count;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: vector table plus reset, stray-ready,
// counter-wrap and (with BUS_TIMEOUT_EN) abort sequences, scoreboarded on cpu_ready.
module tb_mem_bus_bridge;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 4;
   localparam int TMO     = 4;
   localparam int CNT_MSK = (1 << CNT_W) - 1;

   logic clock;
   logic reset;

   mem_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) b ();

   mem_bus_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (b.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          nwait;
      logic [31:0] rdata;
      bit          hold;
   } vec_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] m_rdata  = '0;
   int          m_count  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: every cpu_ready pulse must match a pending request.
   always @(negedge clock) begin
      if (reset && b.cpu_ready === 1'b1) begin
         if (sb_q.size() == 0) chk("unexpected_cpu_ready", 1, 0);
         else chk("sb_cpu_rdata", {32'h0, b.cpu_rdata}, {32'h0, sb_q.pop_front()});
      end
   end

   task automatic do_txn(input vec_t v);
      int vcyc;
      bit stable;
      @(negedge clock);
      b.cpu_req = 1'b1;  b.cpu_rw = v.rw;
      b.cpu_address = v.addr;  b.cpu_wdata = v.wdata;
      if (v.rw) m_rdata = v.rdata;
      m_count++;
      sb_q.push_back(m_rdata);
      @(posedge clock); #1;
      if (!v.hold) begin
         b.cpu_req = 1'b0;  b.cpu_rw = ~v.rw;
         b.cpu_address = ~v.addr;  b.cpu_wdata = ~v.wdata;
      end
      vcyc = 0;  stable = 1'b1;
      for (int k = 0; k <= v.nwait; k++) begin
         @(negedge clock);
         if (b.mem_valid === 1'b1) vcyc++;
         if (b.mem_addr !== v.addr || b.mem_wdata !== v.wdata || b.mem_we !== ~v.rw) stable = 1'b0;
         b.mem_ready = (k == v.nwait);
         b.mem_rdata = (k == v.nwait) ? v.rdata : $urandom;
      end
      @(posedge clock); #1;
      b.mem_ready = 1'b0;  b.mem_rdata = $urandom;
      @(negedge clock);
      chk("done_cpu_ready", {63'h0, b.cpu_ready}, 64'd1);
      chk("done_mem_valid", {63'h0, b.mem_valid}, 64'd0);
      chk("wait_cycles", 64'(vcyc), 64'(v.nwait + 1));
      chk("mem_regs_stable", {63'h0, stable}, 64'd1);
      @(posedge clock); #1;
      if (v.hold) b.cpu_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk("idle_busy", {63'h0, b.cpu_busy}, 64'd0);
         chk("idle_ready", {63'h0, b.cpu_ready}, 64'd0);
      end
      chk("txn_count", {60'h0, b.txn_count}, 64'(m_count & CNT_MSK));
      chk("bus_err_clear", {63'h0, b.bus_err}, 64'd0);
   endtask

   vec_t vt[6];
   vec_t v;

   initial begin
      reset = 1'b0;
      b.cpu_req = 0;  b.cpu_rw = 0;  b.cpu_address = '0;  b.cpu_wdata = '0;
      b.mem_ready = 0;  b.mem_rdata = '0;

      vt[0] = '{1'b1, 32'h100,  32'h0,        0, 32'hCAFE0001, 1'b0};
      vt[1] = '{1'b0, 32'h44,   32'h12345678, 3, 32'h0,        1'b0};
      vt[2] = '{1'b1, 32'h200,  32'h5555AAAA, 1, 32'hA5A55A5A, 1'b0};
      vt[3] = '{1'b0, 32'h8,    32'hDEADBEEF, 0, 32'h77777777, 1'b0};
      vt[4] = '{1'b1, 32'h300,  32'h0,        2, 32'h0BADF00D, 1'b1};
      vt[5] = '{1'b0, 32'h1234, 32'h600DD00D, 0, 32'h0,        1'b1};

      #1;
      chk("rst_mem_valid", {63'h0, b.mem_valid}, 64'd0);
      chk("rst_cpu_busy",  {63'h0, b.cpu_busy},  64'd0);
      chk("rst_cpu_ready", {63'h0, b.cpu_ready}, 64'd0);
      chk("rst_txn_count", {60'h0, b.txn_count}, 64'd0);
      chk("rst_cpu_rdata", {32'h0, b.cpu_rdata}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      foreach (vt[i]) do_txn(vt[i]);

      // Stray mem_ready while idle must be ignored.
      @(negedge clock);
      b.mem_ready = 1'b1;  b.mem_rdata = 32'h13579BDF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("stray_busy", {63'h0, b.cpu_busy}, 64'd0);
         chk("stray_rdata", {32'h0, b.cpu_rdata}, {32'h0, m_rdata});
      end
      b.mem_ready = 1'b0;

`ifdef BUS_TIMEOUT_EN
      begin
         int waits;
         bit seen;
         @(negedge clock);
         b.cpu_req = 1'b1;  b.cpu_rw = 1'b1;  b.cpu_address = 32'h500;
         m_rdata = '1;  m_count++;
         sb_q.push_back(m_rdata);
         @(posedge clock); #1 b.cpu_req = 1'b0;
         waits = 0;  seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (b.cpu_ready === 1'b1) seen = 1'b1;
            else if (b.mem_valid === 1'b1) waits++;
         end
         chk("tmo_ready_seen", {63'h0, seen}, 64'd1);
         chk("tmo_wait_cycles", 64'(waits), 64'(TMO));
         chk("tmo_bus_err", {63'h0, b.bus_err}, 64'd1);
         chk("tmo_rdata", {32'h0, b.cpu_rdata}, 64'hFFFFFFFF);
         v = '{1'b0, 32'h600, 32'h1, 0, 32'h0, 1'b0};
         do_txn(v);
      end
`endif

      // Reset asserted mid-WAIT, away from a clock edge.
      @(negedge clock);
      b.cpu_req = 1'b1;  b.cpu_rw = 1'b1;  b.cpu_address = 32'h700;
      @(posedge clock); #1 b.cpu_req = 1'b0;
      @(negedge clock);
      chk("pre_rst_valid", {63'h0, b.mem_valid}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_mem_valid", {63'h0, b.mem_valid}, 64'd0);
      chk("midrst_cpu_busy",  {63'h0, b.cpu_busy},  64'd0);
      sb_q.delete();
      m_count = 0;  m_rdata = '0;
      @(negedge clock);
      b.mem_ready = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("postrst_busy",  {63'h0, b.cpu_busy},  64'd0);
         chk("postrst_ready", {63'h0, b.cpu_ready}, 64'd0);
      end
      b.mem_ready = 1'b0;
      chk("postrst_txn_count", {60'h0, b.txn_count}, 64'd0);

      // Drive the counter to all-ones, then one more to wrap.
      for (int i = 0; i < CNT_MSK; i++) begin
         v.rw = i[0];  v.addr = $urandom;  v.wdata = $urandom;
         v.nwait = i % 3;  v.rdata = $urandom;  v.hold = 1'b0;
         do_txn(v);
      end
      chk("count_all_ones", {60'h0, b.txn_count}, 64'(CNT_MSK));
      v = '{1'b1, 32'h900, 32'h0, 0, 32'h89ABCDEF, 1'b0};
      do_txn(v);
      chk("count_wrapped", {60'h0, b.txn_count}, 64'd0);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
